// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART serializer that pops bytes from the TX FIFO and frames them onto serial_out
module fifo_uart_tx #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int WIDTH = 8,
  parameter int PARITY = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_enable,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_dout,
  output logic                 serial_out,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] frames_sent
);
  localparam int SET = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = SET > 1 ? $clog2(SET) : 1;
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cyc;
  logic [BW-1:0] bit_cnt;
  logic [WIDTH-1:0] sh;
  logic par, last_cyc, last_bit, adv, so_n;
  assign last_cyc = cyc == CW'(SET - 1);
  assign last_bit = bit_cnt == BW'(WIDTH - 1);
  assign fifo_rd_en = state == IDLE && tx_enable && !fifo_empty && !rst;
  assign adv = state == IDLE ? fifo_rd_en : last_cyc;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fifo_rd_en ? START : IDLE;
      START:   state_n = last_cyc ? DATA : START;
      DATA:    state_n = last_cyc && last_bit ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:     state_n = last_cyc ? STOP : PAR;
      STOP:    state_n = last_cyc ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // sh[0] always holds the next data bit to put on the line
  assign so_n = state_n == START ? 1'b0 : state_n == DATA ? sh[0] : state_n == PAR ? par : 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cyc <= '0;
      bit_cnt <= '0;
      serial_out <= 1'b1;
      busy <= 1'b0;
      frames_sent <= '0;
    end else begin
      state <= state_n;
      cyc <= adv || state == IDLE ? '0 : cyc + 1'b1;
      bit_cnt <= adv ? (state == DATA ? bit_cnt + 1'b1 : '0) : bit_cnt;
      serial_out <= adv ? so_n : serial_out;
      busy <= state_n != IDLE;
      frames_sent <= frames_sent + CNT_WIDTH'(state == STOP && last_cyc);
    end
  end
  always_ff @(posedge clk) begin
    if (fifo_rd_en) begin
      sh <= fifo_dout;
      par <= ^fifo_dout ^ (PARITY == 2);
    end else if (adv && state_n == DATA) begin
      sh <= sh >> 1;
    end
  end
endmodule
